// File: rtl/seq_pkg.sv
// Shared types and default widths for the serial sequence stage and its consumers.
package seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seq_state_t;

    localparam int PAT_W_DEF     = 3;
    localparam int FRAME_LEN_DEF = 16;
    localparam int CNT_W_DEF     = 5;

    // Bits needed to hold the values 0..max_val.
    function automatic int cnt_bits(input int max_val);
        return $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/seq_shift_win.sv
// Sliding PAT_W-bit window over the valid serial bits; flags a hit when the
// window (including the bit being shifted in) is full and equals the pattern.
module seq_shift_win
    import seq_pkg::*;
#(
    parameter int PAT_W = PAT_W_DEF
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             shift_i,
    input  logic             bit_i,
    input  logic [PAT_W-1:0] pat_i,
    output logic             hit_o
);

    localparam int FILL_W = cnt_bits(PAT_W);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W);
    localparam logic [FILL_W-1:0] FILL_THR = FILL_W'(PAT_W - 1);

    // Only the older PAT_W-1 bits need storing; the newest bit is bit_i itself.
    logic [PAT_W-2:0]  sr_q, sr_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic [PAT_W-1:0]  win;

    assign win = {sr_q, bit_i};

    always_comb begin
        sr_d   = sr_q;
        fill_d = fill_q;
        if (clr_i) begin
            sr_d   = '0;
            fill_d = '0;
        end else if (shift_i) begin
            sr_d = win[PAT_W-2:0];
            if (fill_q != FILL_MAX) begin
                fill_d = fill_q + FILL_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sr_q   <= '0;
            fill_q <= '0;
        end else begin
            sr_q   <= sr_d;
            fill_q <= fill_d;
        end
    end

    assign hit_o = shift_i && (fill_q >= FILL_THR) && (win == pat_i);

endmodule

// File: rtl/seq_match_counter.sv
// Counts overlapping pattern hits over one frame of FRAME_LEN valid serial bits.
//  state | meaning
//  IDLE  | waiting for start; count holds last frame's total
//  RUN   | accepting valid bits, pulsing match on each hit
//  DONE  | one-cycle frame-complete pulse, then back to IDLE
module seq_match_counter
    import seq_pkg::*;
#(
    parameter int PAT_W     = PAT_W_DEF,
    parameter int FRAME_LEN = FRAME_LEN_DEF,
    parameter int CNT_W     = CNT_W_DEF
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             bit_in_i,
    input  logic             bit_vld_i,
    input  logic [PAT_W-1:0] pattern_i,
    output logic             match_o,
    output logic [CNT_W-1:0] count_o,
    output logic             busy_o,
    output logic             done_o
);

    localparam int NB_W = cnt_bits(FRAME_LEN);
    localparam logic [NB_W-1:0] LAST_BIT = NB_W'(FRAME_LEN - 1);

    seq_state_t       state_q, state_d;
    logic [NB_W-1:0]  nbits_q, nbits_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [PAT_W-1:0] pat_q, pat_d;
    logic             match_q, match_d;
    logic             accept, shift, hit;

    assign accept = (state_q == IDLE) && start_i;
    assign shift  = (state_q == RUN) && bit_vld_i;

    seq_shift_win #(
        .PAT_W (PAT_W)
    ) u_win (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clr_i   (accept),
        .shift_i (shift),
        .bit_i   (bit_in_i),
        .pat_i   (pat_q),
        .hit_o   (hit)
    );

    always_comb begin
        state_d = state_q;
        nbits_d = nbits_q;
        count_d = count_q;
        pat_d   = pat_q;
        match_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = RUN;
                    pat_d   = pattern_i;
                    count_d = '0;
                    nbits_d = '0;
                end
            end
            RUN: begin
                if (bit_vld_i) begin
                    nbits_d = nbits_q + NB_W'(1);
                    if (hit) begin
                        match_d = 1'b1;
                        if (count_q != {CNT_W{1'b1}}) begin
                            count_d = count_q + CNT_W'(1);
                        end
                    end
                    if (nbits_q == LAST_BIT) begin
                        state_d = DONE;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            nbits_q <= '0;
            count_q <= '0;
            pat_q   <= '0;
            match_q <= 1'b0;
        end else begin
            state_q <= state_d;
            nbits_q <= nbits_d;
            count_q <= count_d;
            pat_q   <= pat_d;
            match_q <= match_d;
        end
    end

    assign match_o = match_q;
    assign count_o = count_q;
    assign busy_o  = (state_q == RUN);
    assign done_o  = (state_q == DONE);

endmodule
